// File: rtl/fp_pkg.sv
// Shared floating-point constants for the divider front-end.
package fp_pkg;
  localparam int FP_W    = 32;
  localparam int FLAGS_W = 5;

  // Exception flag bit positions within the flags bus
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;
endpackage

// File: rtl/fp_tag_fifo.sv
// Tag FIFO holding the requester ID of each operation issued to the divider.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module fp_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_id,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign head   = r_mem[r_rd_ptr];
  assign count  = r_count;

  // Storage write; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_id;
  end

  // Pointer and occupancy tracking; the extra count bit separates full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/fp_div_arbiter.sv
// Round-robin arbiter sharing one divider among NUM_REQ requesters; a tag FIFO
// routes each in-order result back to the requester that issued it.
module fp_div_arbiter
  import fp_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*FP_W-1:0]       req_op_a,
  input  logic [NUM_REQ*FP_W-1:0]       req_op_b,
  input  logic [NUM_REQ-1:0]            req_mode_fp,
  input  logic [NUM_REQ-1:0]            req_round_mode,
  output logic [NUM_REQ-1:0]            resp_valid,
  input  logic [NUM_REQ-1:0]            resp_ready,
  output logic [FP_W-1:0]               resp_result,
  output logic [FLAGS_W-1:0]            resp_flags,
  output logic                          unit_start,
  input  logic                          unit_ready_out,
  output logic [FP_W-1:0]               unit_op_a,
  output logic [FP_W-1:0]               unit_op_b,
  output logic                          unit_mode_fp,
  output logic                          unit_round_mode,
  input  logic                          unit_valid_out,
  output logic                          unit_ready_in,
  input  logic [FP_W-1:0]               unit_result,
  input  logic [FLAGS_W-1:0]            unit_flags,
  output logic [$clog2(MAX_INFLIGHT):0] inflight,
  output logic                          orphan_err
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0] r_rr_ptr;
  logic            r_orphan_err;
  logic [ID_W-1:0] w_gnt_id;
  logic [ID_W-1:0] w_head_id;
  logic            w_any_req;
  logic            w_full;
  logic            w_empty;
  logic            w_issue_ok;
  logic            w_accept;
  logic            w_pop;

  assign w_any_req  = |req_valid;
  // Outputs that launch or consume transfers are held low while in reset
  assign w_issue_ok = rst_n && w_any_req && !w_full;
  assign w_accept   = w_issue_ok && unit_ready_out;
  assign unit_start = w_issue_ok;
  assign orphan_err = r_orphan_err;

  assign resp_result = unit_result;
  assign resp_flags  = unit_flags;

  // Round-robin search for the first valid requester at or after the pointer
  always_comb begin : rr_search
    logic [ID_W:0] cand;
    logic          found;
    w_gnt_id = '0;
    found    = 1'b0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!found && req_valid[cand[ID_W-1:0]]) begin
        found    = 1'b1;
        w_gnt_id = cand[ID_W-1:0];
      end
    end
  end

  // Steer the granted requester onto the divider issue port
  always_comb begin
    req_ready       = '0;
    unit_op_a       = '0;
    unit_op_b       = '0;
    unit_mode_fp    = 1'b0;
    unit_round_mode = 1'b0;
    if (w_accept) req_ready[w_gnt_id] = 1'b1;
    if (w_any_req) begin
      unit_op_a       = req_op_a[int'(w_gnt_id)*FP_W +: FP_W];
      unit_op_b       = req_op_b[int'(w_gnt_id)*FP_W +: FP_W];
      unit_mode_fp    = req_mode_fp[w_gnt_id];
      unit_round_mode = req_round_mode[w_gnt_id];
    end
  end

  // Route the divider result to the FIFO head owner; drain strays when empty
  always_comb begin
    resp_valid    = '0;
    unit_ready_in = 1'b0;
    w_pop         = 1'b0;
    if (rst_n) begin
      if (!w_empty) begin
        resp_valid[w_head_id] = unit_valid_out;
        unit_ready_in         = resp_ready[w_head_id];
        w_pop                 = unit_valid_out && resp_ready[w_head_id];
      end else begin
        unit_ready_in = unit_valid_out;
      end
    end
  end

  // Pointer moves just past the winner on every accepted issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= (w_gnt_id == ID_W'(NUM_REQ-1)) ? '0 : w_gnt_id + ID_W'(1);
    end
  end

  // Sticky flag for a divider result that no outstanding tag can claim
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_orphan_err <= 1'b0;
    end else if (unit_valid_out && w_empty) begin
      r_orphan_err <= 1'b1;
    end
  end

  fp_tag_fifo #(
    .WIDTH (ID_W),
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (w_accept),
    .push_id (w_gnt_id),
    .pop     (w_pop),
    .head    (w_head_id),
    .full    (w_full),
    .empty   (w_empty),
    .count   (inflight)
  );
endmodule

// File: tb/tb_fp_div_arbiter.sv
// Bench for fp_div_arbiter: the bench also plays the divider (in-order, one
// result per cycle when allowed) and keeps a queue-based reference model.
module tb_fp_div_arbiter;
  import fp_pkg::*;

  localparam int N    = 4;
  localparam int MAXI = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid, req_ready, req_mode_fp, req_round_mode;
  logic [N-1:0]    resp_valid, resp_ready;
  logic [N*32-1:0] req_op_a, req_op_b;
  logic [31:0]     resp_result, unit_op_a, unit_op_b, unit_result;
  logic [4:0]      resp_flags, unit_flags;
  logic            unit_start, unit_ready_out, unit_mode_fp, unit_round_mode;
  logic            unit_valid_out, unit_ready_in, orphan_err;
  logic [2:0]      inflight;

  fp_div_arbiter #(.NUM_REQ(N), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b),
    .req_mode_fp(req_mode_fp), .req_round_mode(req_round_mode),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_flags(resp_flags),
    .unit_start(unit_start), .unit_ready_out(unit_ready_out),
    .unit_op_a(unit_op_a), .unit_op_b(unit_op_b),
    .unit_mode_fp(unit_mode_fp), .unit_round_mode(unit_round_mode),
    .unit_valid_out(unit_valid_out), .unit_ready_in(unit_ready_in),
    .unit_result(unit_result), .unit_flags(unit_flags),
    .inflight(inflight), .orphan_err(orphan_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Divider stand-in: real division through doubles, result truncated; NX if inexact
  function automatic logic [63:0] s2d(input logic [31:0] s);
    return {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0};
  endfunction

  function automatic logic [36:0] fdiv(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] d;
    logic [10:0] e;
    real         q;
    if (b[30:0] == 31'd0) begin
      if (a[30:0] == 31'd0) return {32'h7FC00000, 5'b10000};
      return {a[31] ^ b[31], 31'h7F800000, 5'b01000};
    end
    if (a[30:0] == 31'd0) return {a[31] ^ b[31], 31'd0, 5'd0};
    q = $bitstoreal(s2d(a)) / $bitstoreal(s2d(b));
    d = $realtobits(q);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29], 4'b0000, |d[28:0]};
  endfunction

  function automatic logic [31:0] rnd_norm();
    return {1'($urandom), 8'($urandom_range(110, 144)), 23'($urandom)};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (p + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Reference model state
  int          m_ptr;
  int          m_tags[$];
  bit          m_orphan;
  logic [63:0] div_q[$];
  logic [36:0] exp_q[N][$];
  logic        dv_want, dv_force;

  // Values captured mid-cycle for the clock-edge update
  bit          c_acc, c_ret;
  int          c_g, c_h;
  logic [31:0] c_a, c_b;
  logic [36:0] c_res;

  task automatic model_reset();
    m_ptr = 0;
    m_tags.delete();
    m_orphan = 0;
    div_q.delete();
    for (int i = 0; i < N; i++) exp_q[i].delete();
  endtask

  task automatic drive_op(input int id, input logic [31:0] a, input logic [31:0] b);
    req_op_a[id*32 +: 32] = a;
    req_op_b[id*32 +: 32] = b;
  endtask

  // Drive the divider side, settle, and compare every output with the model
  task automatic eval();
    logic [N-1:0] e_rr, e_rv;
    logic [1:0]   e_mode;
    int           g;
    bit           full, empty;
    logic         e_uri;
    unit_valid_out = dv_force || (dv_want && div_q.size() != 0);
    if (div_q.size() != 0) {unit_result, unit_flags} = fdiv(div_q[0][63:32], div_q[0][31:0]);
    else {unit_result, unit_flags} = {32'hDEADBEEF, 5'h1F};
    #1;
    g     = rr_pick(req_valid, m_ptr);
    full  = (m_tags.size() == MAXI);
    empty = (m_tags.size() == 0);
    c_acc = (g >= 0) && !full && unit_ready_out;
    e_rr  = '0;
    if (c_acc) e_rr[g] = 1'b1;
    chk("req_ready", req_ready, e_rr);
    chk("unit_start", unit_start, (g >= 0) && !full);
    c_a = '0; c_b = '0; e_mode = '0;
    if (g >= 0) begin
      c_a = req_op_a[g*32 +: 32];
      c_b = req_op_b[g*32 +: 32];
      e_mode = {req_mode_fp[g], req_round_mode[g]};
    end
    chk("unit_ops", {unit_op_a, unit_op_b}, {c_a, c_b});
    chk("unit_mode", {unit_mode_fp, unit_round_mode}, e_mode);
    c_h  = empty ? -1 : m_tags[0];
    e_rv = '0;
    if (!empty && unit_valid_out) e_rv[c_h] = 1'b1;
    e_uri = empty ? unit_valid_out : resp_ready[c_h];
    chk("resp_valid", resp_valid, e_rv);
    chk("unit_ready_in", unit_ready_in, e_uri);
    chk("inflight", inflight, m_tags.size());
    chk("orphan_err", orphan_err, m_orphan);
    chk("resp_pass", {resp_result, resp_flags}, {unit_result, unit_flags});
    c_ret = unit_valid_out && e_uri;
    c_g   = g;
    c_res = {resp_result, resp_flags};
  endtask

  // Advance the model across the rising edge, scoring each retired result
  task automatic commit();
    logic [36:0] want;
    @(posedge clk);
    if (c_ret) begin
      if (c_h >= 0) begin
        chk("sb_pending", exp_q[c_h].size() != 0, 1);
        if (exp_q[c_h].size() != 0) begin
          want = exp_q[c_h].pop_front();
          chk("sb_result", c_res, want);
        end
        void'(m_tags.pop_front());
        void'(div_q.pop_front());
      end else begin
        m_orphan = 1;
      end
    end
    if (c_acc) begin
      m_tags.push_back(c_g);
      m_ptr = (c_g + 1) % N;
      div_q.push_back({c_a, c_b});
      exp_q[c_g].push_back(fdiv(c_a, c_b));
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    req_valid = '0;
    dv_want = 0;
    dv_force = 0;
    unit_valid_out = 0;
    rst_n = 0;
    #2;
    rst_n = 1;
    model_reset();
    @(negedge clk);
  endtask

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  flg;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [N-1:0] ex;
    vecs[0] = '{1, 32'h40400000, 32'h40000000, 32'h3FC00000, 5'b00000};
    vecs[1] = '{2, 32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000};
    vecs[2] = '{0, 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000};
    vecs[3] = '{3, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 5'b00001};
    vecs[4] = '{2, 32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000};

    req_valid = '1; req_op_a = '0; req_op_b = '0;
    req_mode_fp = '0; req_round_mode = '0; resp_ready = '1;
    unit_ready_out = 1; unit_valid_out = 1; unit_result = '0; unit_flags = '0;
    dv_want = 0; dv_force = 0;
    model_reset();

    // Outputs held low during reset even with every input asserted
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_unit_start", unit_start, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_unit_ready_in", unit_ready_in, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_orphan", orphan_err, 0);
    @(negedge clk);
    req_valid = '0;
    unit_valid_out = 0;
    rst_n = 1;
    @(negedge clk);

    // Single-op vectors: one-hot grant, then routed result and flags
    foreach (vecs[i]) begin
      req_valid = '0;
      req_valid[vecs[i].id] = 1'b1;
      drive_op(vecs[i].id, vecs[i].a, vecs[i].b);
      dv_want = 0;
      eval();
      ex = '0; ex[vecs[i].id] = 1'b1;
      chk("vec_req_ready", req_ready, ex);
      commit();
      req_valid = '0;
      dv_want = 1;
      eval();
      chk("vec_resp_valid", resp_valid, ex);
      chk("vec_result", resp_result, vecs[i].res);
      chk("vec_flags", resp_flags, vecs[i].flg);
      commit();
    end

    // Fairness: all requesters valid, unit always ready
    apply_reset();
    resp_ready = '1; unit_ready_out = 1; dv_want = 1; req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < N; k++)
        drive_op(k, 32'h40000000 + 32'((i * 4 + k) << 16), 32'h3FC00000 + 32'(k << 18));
      eval();
      ex = '0; ex[i % N] = 1'b1;
      chk("fair_grant", req_ready, ex);
      commit();
    end
    req_valid = '0;
    repeat (4) begin eval(); commit(); end

    // Backpressure: result held while the owner stalls
    apply_reset();
    req_valid = 4'b0001; drive_op(0, 32'h40400000, 32'h40000000);
    resp_ready = '1; dv_want = 0;
    eval(); chk("bp_issue", req_ready, 4'b0001); commit();
    req_valid = '0; resp_ready = 4'b1110; dv_want = 1;
    repeat (3) begin
      eval();
      chk("bp_hold_valid", resp_valid, 4'b0001);
      chk("bp_hold_uri", unit_ready_in, 0);
      chk("bp_hold_result", resp_result, 32'h3FC00000);
      commit();
    end
    resp_ready = '1;
    eval(); chk("bp_release_uri", unit_ready_in, 1); commit();
    eval(); chk("bp_empty", inflight, 0); commit();

    // Fill the tag FIFO with no retire, then pop while full
    dv_want = 0; req_valid = '1;
    for (int k = 0; k < N; k++) drive_op(k, rnd_norm(), rnd_norm());
    repeat (MAXI) begin eval(); commit(); end
    eval();
    chk("full_inflight", inflight, MAXI);
    chk("full_block", req_ready, 0);
    commit();
    dv_want = 1;
    eval();
    chk("full_pop_block", req_ready, 0);
    chk("full_pop_uri", unit_ready_in, 1);
    commit();
    eval(); chk("full_reissue", |req_ready, 1); commit();
    req_valid = '0;
    repeat (8) begin eval(); commit(); end

    // Orphan result with an empty FIFO
    dv_force = 1; dv_want = 0;
    eval();
    chk("orph_resp_valid", resp_valid, 0);
    chk("orph_uri", unit_ready_in, 1);
    commit();
    dv_force = 0;
    repeat (3) begin eval(); chk("orph_sticky", orphan_err, 1); commit(); end

    // Reset mid-flight with three ops outstanding
    req_valid = '1; unit_ready_out = 1; dv_want = 0;
    repeat (3) begin eval(); commit(); end
    chk("mid_outstanding", inflight, 3);
    #1;
    unit_valid_out = 1;
    rst_n = 0;
    #1;
    chk("mid_inflight", inflight, 0);
    chk("mid_req_ready", req_ready, 0);
    chk("mid_unit_start", unit_start, 0);
    chk("mid_resp_valid", resp_valid, 0);
    chk("mid_uri", unit_ready_in, 0);
    chk("mid_orphan", orphan_err, 0);
    model_reset();
    rst_n = 1;
    eval();
    chk("mid_first_grant", req_ready, 4'b0001);
    commit();
    req_valid = '0;
    dv_want = 1;
    repeat (4) begin eval(); commit(); end

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      req_valid = N'($urandom);
      for (int k = 0; k < N; k++) drive_op(k, rnd_norm(), rnd_norm());
      req_mode_fp = N'($urandom);
      req_round_mode = N'($urandom);
      resp_ready = N'($urandom);
      unit_ready_out = ($urandom_range(0, 3) != 0);
      dv_want = ($urandom_range(0, 2) != 0);
      eval();
      commit();
    end
    req_valid = '0; resp_ready = '1; dv_want = 1;
    for (int i = 0; i < 20 && m_tags.size() != 0; i++) begin eval(); commit(); end
    eval();
    chk("drain_inflight", inflight, 0);
    commit();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
